// File: rtl/sram_line_responder.sv
// Line-wide single-port backing memory for the cache refill/writeback port.
// Optional build macro SRAM_ZERO_INIT_EN clears every line after reset (busy while clearing).
module sram_line_responder #(
  parameter int SRAM_ADDR_BIT = 12,
  parameter int SRAM_DATA_BIT = 128,
  parameter int MEM_DEPTH_BIT = 8,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SRAM_ena_i,
  input  logic                     SRAM_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] SRAM_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,
  output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
  output logic                     SRAM_valid_o,
  output logic                     SRAM_err_o,
  output logic                     SRAM_busy_o
);

  // state   | meaning
  // INIT    | clearing lines 0..2**MEM_DEPTH_BIT-1, requests ignored (SRAM_ZERO_INIT_EN only)
  // IDLE    | accepting one read or write per cycle

  localparam int LINES = 2 ** MEM_DEPTH_BIT;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (MEM_DEPTH_BIT > SRAM_ADDR_BIT) begin : g_bad_depth
    $error("MEM_DEPTH_BIT must not exceed SRAM_ADDR_BIT");
  end
  if ((SRAM_DATA_BIT % 8) != 0) begin : g_bad_width
    $error("SRAM_DATA_BIT must be a multiple of 8");
  end

`ifdef SRAM_ZERO_INIT_EN
  typedef enum logic {ST_IDLE, ST_INIT} state_t;
`else
  typedef enum logic {ST_IDLE} state_t;
`endif

  state_t                     r_state;
  logic [SRAM_DATA_BIT-1:0]   r_mem [LINES];
  logic                       r_wr_err;
  logic [READ_LATENCY-1:0]    r_stg_vld;
  logic [READ_LATENCY-1:0]    r_stg_err;
  logic [SRAM_DATA_BIT-1:0]   r_stg_data [READ_LATENCY];

  logic                       w_accept;
  logic                       w_rd_acc;
  logic                       w_wr_acc;
  logic                       w_in_range;
  logic [MEM_DEPTH_BIT-1:0]   w_line;
  logic [SRAM_DATA_BIT-1:0]   w_rd_line;
  logic                       w_mem_we;
  logic [MEM_DEPTH_BIT-1:0]   w_mem_waddr;
  logic [SRAM_DATA_BIT-1:0]   w_mem_wdata;

  assign w_line   = SRAM_addr_i[MEM_DEPTH_BIT-1:0];
  assign w_accept = SRAM_ena_i & (r_state == ST_IDLE);
  assign w_wr_acc = w_accept & SRAM_wea_i;
  assign w_rd_acc = w_accept & ~SRAM_wea_i;

  if (SRAM_ADDR_BIT > MEM_DEPTH_BIT) begin : g_range_chk
    assign w_in_range = ~|SRAM_addr_i[SRAM_ADDR_BIT-1:MEM_DEPTH_BIT];
  end else begin : g_range_full
    assign w_in_range = 1'b1;
  end

`ifdef SRAM_ZERO_INIT_EN
  logic [MEM_DEPTH_BIT-1:0] r_init_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (&r_init_cnt) r_state <= ST_IDLE;
    end
  end

  // the clearing walk owns the single write port while busy
  assign SRAM_busy_o = (r_state == ST_INIT);
  assign w_mem_we    = (r_state == ST_INIT) | (w_wr_acc & w_in_range);
  assign w_mem_waddr = (r_state == ST_INIT) ? r_init_cnt : w_line;
  assign w_mem_wdata = (r_state == ST_INIT) ? '0 : SRAM_data_i;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= ST_IDLE;
  end

  assign SRAM_busy_o = 1'b0;
  assign w_mem_we    = w_wr_acc & w_in_range;
  assign w_mem_waddr = w_line;
  assign w_mem_wdata = SRAM_data_i;
`endif

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  assign w_rd_line = r_mem[w_line];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_err <= 1'b0;
    else        r_wr_err <= w_wr_acc & ~w_in_range;
  end

  // data registers only load behind a valid stage, so the output holds the last read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld <= '0;
      r_stg_err <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_stg_data[i] <= '0;
    end else begin
      r_stg_vld[0] <= w_rd_acc;
      r_stg_err[0] <= w_rd_acc & ~w_in_range;
      if (w_rd_acc) r_stg_data[0] <= w_in_range ? w_rd_line : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_stg_vld[i] <= r_stg_vld[i-1];
        r_stg_err[i] <= r_stg_err[i-1];
        if (r_stg_vld[i-1]) r_stg_data[i] <= r_stg_data[i-1];
      end
    end
  end

  assign SRAM_data_o  = r_stg_data[READ_LATENCY-1];
  assign SRAM_valid_o = r_stg_vld[READ_LATENCY-1];
  assign SRAM_err_o   = r_wr_err | r_stg_err[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_line_responder.sv
// Self-checking bench for sram_line_responder: directed vector table, hand sequences
// for reset/init corners, and randomized traffic against a queue-based reference model.
module tb_sram_line_responder;
  localparam int AW    = 12;
  localparam int DW    = 128;
  localparam int MDB   = 8;
  localparam int LAT   = 3;
  localparam int LINES = 2 ** MDB;

  localparam logic [DW-1:0] DP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] DA = 128'hA5A5_A5A5_0000_1111_2222_3333_5A5A_5A5A;
  localparam logic [DW-1:0] D1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [DW-1:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [DW-1:0] D3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [DW-1:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [DW-1:0] DB = 128'hB0B0_B0B0_1234_5678_9ABC_DEF0_0F0F_0F0F;
  localparam logic [DW-1:0] DC = 128'hC0C0_FFFF_0000_C0C0_8765_4321_ABCD_EF01;

  logic          clk;
  logic          rst_n;
  logic          SRAM_ena_i;
  logic          SRAM_wea_i;
  logic [AW-1:0] SRAM_addr_i;
  logic [DW-1:0] SRAM_data_i;
  logic [DW-1:0] SRAM_data_o;
  logic          SRAM_valid_o;
  logic          SRAM_err_o;
  logic          SRAM_busy_o;

  sram_line_responder #(
    .SRAM_ADDR_BIT(AW), .SRAM_DATA_BIT(DW), .MEM_DEPTH_BIT(MDB), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .SRAM_ena_i(SRAM_ena_i), .SRAM_wea_i(SRAM_wea_i),
    .SRAM_addr_i(SRAM_addr_i), .SRAM_data_i(SRAM_data_i),
    .SRAM_data_o(SRAM_data_o), .SRAM_valid_o(SRAM_valid_o),
    .SRAM_err_o(SRAM_err_o), .SRAM_busy_o(SRAM_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic          ena;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ev;
    logic          ee;
    logic [DW-1:0] ed;
  } vec_t;

  rsp_t          rq[$];
  int            wq[$];
  logic [DW-1:0] m_mem [LINES];
  logic [DW-1:0] hold_data;
  vec_t          tbl [23];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ena, input logic wea, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic ev, input logic ee,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.ena = ena; v.wea = wea; v.addr = a; v.data = d;
    v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic check_model(input int e);
    logic ev;
    logic ee;
    rsp_t r;
    int   w;
    ev = 1'b0;
    ee = 1'b0;
    if (rq.size() > 0 && rq[0].due == e) begin
      r = rq.pop_front();
      ev = 1'b1;
      ee = r.err;
      hold_data = r.data;
    end
    if (wq.size() > 0 && wq[0] == e) begin
      w = wq.pop_front();
      ee = 1'b1;
    end
    chk("model_valid", DW'(SRAM_valid_o), DW'(ev));
    chk("model_err",   DW'(SRAM_err_o),   DW'(ee));
    chk("model_data",  SRAM_data_o,       hold_data);
    chk("model_busy",  DW'(SRAM_busy_o),  '0);
  endtask

  // one request issued at a negedge, accepted at the following posedge, checked at the next negedge
  task automatic do_cycle(input logic ena, input logic wea, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    int   e;
    logic inr;
    rsp_t r;
    SRAM_ena_i  = ena;
    SRAM_wea_i  = wea;
    SRAM_addr_i = addr;
    SRAM_data_i = data;
    e   = edge_cnt + 1;
    inr = (addr[AW-1:MDB] == '0);
    if (ena) begin
      if (wea) begin
        if (inr) m_mem[addr[MDB-1:0]] = data;
        else     wq.push_back(e);
      end else begin
        r.due  = e + LAT - 1;
        r.data = inr ? m_mem[addr[MDB-1:0]] : '0;
        r.err  = ~inr;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
    SRAM_ena_i = 1'b0;
    check_model(e);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (SRAM_busy_o && n < 2000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      chk("busy_valid", DW'(SRAM_valid_o), '0);
      chk("busy_err",   DW'(SRAM_err_o),   '0);
    end
    if (n >= 2000) begin
      n_assert++;
      n_fail++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", SRAM_busy_o, n);
    end
  endtask

  task automatic random_data(output logic [DW-1:0] d);
    d = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int            n;
    logic          r_ena, r_wea;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    rst_n = 1'b0;
    SRAM_ena_i = 1'b0; SRAM_wea_i = 1'b0; SRAM_addr_i = '0; SRAM_data_i = '0;
    hold_data = '0;

    tbl[0]  = mk(1, 1, 12'h000, DA, 0, 0, '0);
    tbl[1]  = mk(1, 1, 12'h005, DP, 0, 0, '0);
    tbl[2]  = mk(1, 0, 12'h005, '0, 0, 0, '0);
    tbl[3]  = mk(1, 1, 12'h001, D1, 0, 0, '0);
    tbl[4]  = mk(1, 1, 12'h002, D2, 1, 0, DP);
    tbl[5]  = mk(1, 1, 12'h003, D3, 0, 0, DP);
    tbl[6]  = mk(1, 0, 12'h001, '0, 0, 0, DP);
    tbl[7]  = mk(1, 0, 12'h002, '0, 0, 0, DP);
    tbl[8]  = mk(1, 0, 12'h003, '0, 1, 0, D1);
    tbl[9]  = mk(0, 0, 12'h000, '0, 1, 0, D2);
    tbl[10] = mk(0, 0, 12'h000, '0, 1, 0, D3);
    tbl[11] = mk(1, 1, 12'h100, DX, 0, 1, D3);
    tbl[12] = mk(1, 0, 12'h100, '0, 0, 0, D3);
    tbl[13] = mk(1, 0, 12'h000, '0, 0, 0, D3);
    tbl[14] = mk(1, 1, 12'h0A0, DB, 1, 1, '0);
    tbl[15] = mk(1, 0, 12'h0A0, '0, 1, 0, DA);
    tbl[16] = mk(1, 0, 12'h0A0, '0, 0, 0, DA);
    tbl[17] = mk(1, 1, 12'h0B0, DC, 1, 0, DB);
    tbl[18] = mk(1, 1, 12'h0B0, DC, 1, 0, DB);
    tbl[19] = mk(1, 0, 12'h0B0, '0, 0, 0, DB);
    tbl[20] = mk(0, 0, 12'h000, '0, 0, 0, DB);
    tbl[21] = mk(0, 0, 12'h000, '0, 1, 0, DC);
    tbl[22] = mk(0, 0, 12'h000, '0, 0, 0, DC);

    repeat (2) @(negedge clk);
    chk("rst_valid", DW'(SRAM_valid_o), '0);
    chk("rst_err",   DW'(SRAM_err_o),   '0);
    chk("rst_data",  SRAM_data_o,       '0);
`ifdef SRAM_ZERO_INIT_EN
    chk("rst_busy",  DW'(SRAM_busy_o),  DW'(1));
`else
    chk("rst_busy",  DW'(SRAM_busy_o),  '0);
`endif
    rst_n = 1'b1;

`ifdef SRAM_ZERO_INIT_EN
    // a read held during the clearing walk must be ignored
    SRAM_ena_i = 1'b1; SRAM_wea_i = 1'b0; SRAM_addr_i = 12'h003;
    wait_idle(n);
    SRAM_ena_i = 1'b0;
    chk("init_len", DW'(n), DW'(LINES));

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("init_busy_mid", DW'(SRAM_busy_o), DW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(n);
    chk("init_restart_len", DW'(n), DW'(LINES));
    for (int i = 0; i < LINES; i++) m_mem[i] = '0;
    do_cycle(1, 1, 12'h0FE, DX);
    do_cycle(1, 0, 12'h00F, '0);
    repeat (LAT) do_cycle(0, 0, '0, '0);
    chk("init_line_f", SRAM_data_o, '0);
`else
    wait_idle(n);
    chk("noinit_busy_cycles", DW'(n), '0);
`endif

    for (int i = 0; i < 23; i++) begin
      do_cycle(tbl[i].ena, tbl[i].wea, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl_valid[%0d]", i), DW'(SRAM_valid_o), DW'(tbl[i].ev));
      chk($sformatf("tbl_err[%0d]", i),   DW'(SRAM_err_o),   DW'(tbl[i].ee));
      chk($sformatf("tbl_data[%0d]", i),  SRAM_data_o,       tbl[i].ed);
    end

    // reset one cycle after a read is accepted: the response must never appear
    do_cycle(1, 0, 12'h005, '0);
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    hold_data = '0;
    #1;
    chk("midrd_rst_valid", DW'(SRAM_valid_o), '0);
    chk("midrd_rst_data",  SRAM_data_o,       '0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(n);
`ifdef SRAM_ZERO_INIT_EN
    for (int i = 0; i < LINES; i++) m_mem[i] = '0;
`endif
    repeat (LAT + 1) do_cycle(0, 0, '0, '0);

    for (int i = 0; i < LINES; i++) begin
      random_data(r_data);
      do_cycle(1, 1, AW'(i), r_data);
    end

    r_ena = 1'b0; r_wea = 1'b0; r_addr = '0; r_data = '0;
    for (int k = 0; k < 600; k++) begin
      // sometimes hold the previous request, as the cache does through its delay states
      if ($urandom_range(0, 3) != 0 || !r_ena) begin
        r_ena = ($urandom_range(0, 9) < 7);
        r_wea = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) r_addr = AW'($urandom_range(LINES, 2 ** AW - 1));
        else                           r_addr = AW'($urandom_range(0, LINES - 1));
        random_data(r_data);
      end
      do_cycle(r_ena, r_wea, r_addr, r_data);
    end
    repeat (LAT + 1) do_cycle(0, 0, '0, '0);
    chk("drain_rq", DW'(rq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end
endmodule
